// File: rtl/cla11_shift_add_mul_ctrl_pkg.sv
// Shared types and constants for the shift-add multiplier controller.
// Holds the FSM encoding, the shared adder width and the truncation mask helper.
package mul_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int CLA_W = 11;

    // Multiplier bits that survive truncation: bits K..width-1 set, everything else clear.
    function automatic logic [31:0] approx_mask(input int width, input int k);
        return ((32'd1 << width) - 32'd1) & ~((32'd1 << k) - 32'd1);
    endfunction

endpackage

// File: rtl/cla11_shift_add_mul_ctrl_cla11.sv
// 11-bit carry-lookahead adder, carry-in tied low.
// Each carry is the flat OR of every generate term propagated up to it.
module cla11
    import mul_ctrl_pkg::*;
(
    output logic [CLA_W-1:0] sum,
    output logic             cout,
    input  logic [CLA_W-1:0] a,
    input  logic [CLA_W-1:0] b
);

    logic [CLA_W-1:0] g;
    logic [CLA_W-1:0] p;
    logic [CLA_W:0]   c;
    logic             term;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        term = 1'b0;
        for (int i = 0; i < CLA_W; i++) begin
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                c[i+1] = c[i+1] | term;
            end
        end
    end

    assign sum  = p ^ c[CLA_W-1:0];
    assign cout = c[CLA_W];

endmodule

// File: rtl/cla11_shift_add_mul_ctrl.sv
// Multi-cycle shift-add multiplier: one conditional add per clock through a shared CLA11.
// H:L is the running product register; L starts as the multiplier and shifts out LSB-first.
module cla11_shift_add_mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int APPROX_K = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PAD   = CLA_W - WIDTH;
    localparam int KW    = 1 << CNT_W;
    // Indexed by step count: a clear bit forces that partial product to zero.
    localparam logic [KW-1:0] KEEP = KW'(approx_mask(WIDTH, APPROX_K));

    if (WIDTH < 2 || WIDTH > CLA_W - 1 || APPROX_K < 0 || APPROX_K >= WIDTH) begin : g_bad_params
        $error("cla11_shift_add_mul_ctrl: need 2<=WIDTH<=10 and 0<=APPROX_K<WIDTH");
    end

    state_t             state;
    logic [WIDTH-1:0]   m_q;
    logic [WIDTH-1:0]   h_q;
    logic [WIDTH-1:0]   l_q;
    logic [CNT_W-1:0]   cnt;

    logic               add_bit;
    logic [CLA_W-1:0]   cla_a;
    logic [CLA_W-1:0]   cla_b;
    logic [CLA_W-1:0]   cla_sum;
    logic               cla_cout;
    logic [WIDTH:0]     s;
    logic [WIDTH-1:0]   h_nxt;
    logic [WIDTH-1:0]   l_nxt;
    logic               unused_cla;

    assign in_ready = (state == ST_IDLE);

    assign add_bit = l_q[0] & KEEP[cnt];
    assign cla_a   = {{PAD{1'b0}}, h_q};
    assign cla_b   = add_bit ? {{PAD{1'b0}}, m_q} : '0;

    cla11 u_cla (
        .sum  (cla_sum),
        .cout (cla_cout),
        .a    (cla_a),
        .b    (cla_b)
    );

    // H and M are both < 2^WIDTH, so the sum fits in WIDTH+1 bits and the rest is always zero.
    assign s          = cla_sum[WIDTH:0];
    assign h_nxt      = s[WIDTH:1];
    assign l_nxt      = {s[0], l_q[WIDTH-1:1]};
    assign unused_cla = ^{cla_cout, cla_sum};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            m_q         <= '0;
            h_q         <= '0;
            l_q         <= '0;
            cnt         <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        m_q   <= in_a;
                        h_q   <= '0;
                        l_q   <= in_b;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    h_q <= h_nxt;
                    l_q <= l_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        out_product <= {h_nxt, l_nxt};
                        out_valid   <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Product stays registered after handoff; only the valid drops.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla11_shift_add_mul_ctrl.sv
// Scoreboard bench: an exact (K=0) and a truncating (K=2) controller run in lockstep
// on the same stimulus; expected products are queued at accept and popped at handoff.
module tb_cla11_shift_add_mul_ctrl;
    import mul_ctrl_pkg::*;

    localparam int W = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           in_valid = 1'b0;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           out_ready = 1'b0;

    logic           in_ready0, out_valid0, busy0;
    logic [2*W-1:0] out_product0;
    logic           in_ready2, out_valid2, busy2;
    logic [2*W-1:0] out_product2;

    cla11_shift_add_mul_ctrl #(.WIDTH(W), .APPROX_K(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid0), .out_ready(out_ready),
        .out_product(out_product0), .busy(busy0)
    );

    cla11_shift_add_mul_ctrl #(.WIDTH(W), .APPROX_K(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid2), .out_ready(out_ready),
        .out_product(out_product2), .busy(busy2)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit rand_ready = 1'b0;
    logic [2*W-1:0] q0[$];
    logic [2*W-1:0] q2[$];

    always @(posedge clk) cyc <= cyc + 1;

    wire [1:0]          ov = {out_valid2, out_valid0};
    wire [1:0]          ir = {in_ready2, in_ready0};
    wire [1:0]          bz = {busy2, busy0};
    wire [1:0][2*W-1:0] op = {out_product2, out_product0};

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        logic [31:0] m;
        m = approx_mask(W, k);
        return (2*W)'(32'(a) * 32'(b & m[W-1:0]));
    endfunction

    // Output scoreboard plus handshake-protocol monitor, sampled on the falling edge.
    logic [1:0]          pv = '0;
    logic [1:0][2*W-1:0] pp = '0;
    logic                pr = 1'b0;
    always @(negedge clk) begin
        logic [2*W-1:0] exp_p;
        if (!rst_n) begin
            pv = '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (ir[d] !== !bz[d]) begin
                    miscompares++;
                    $display("FAIL ready_vs_busy dut%0d: in_ready=%0b busy=%0b, required complementary", d, ir[d], bz[d]);
                end
                if (pv[d] && !pr) begin
                    vectors++;
                    if (ov[d] !== 1'b1 || op[d] !== pp[d]) begin
                        miscompares++;
                        $display("FAIL hold_stable dut%0d: valid=%0b product=%0d, required valid=1 product=%0d", d, ov[d], op[d], pp[d]);
                    end
                end
                if (ov[d] && out_ready) begin
                    vectors++;
                    if ((d == 0 ? q0.size() : q2.size()) == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_output dut%0d: product=%0d, required no output", d, op[d]);
                    end else begin
                        exp_p = (d == 0) ? q0.pop_front() : q2.pop_front();
                        if (op[d] !== exp_p) begin
                            miscompares++;
                            $display("FAIL product dut%0d: got %0d, required %0d", d, op[d], exp_p);
                        end
                    end
                end
                pv[d] = ov[d];
                pp[d] = op[d];
            end
        end
        pr = out_ready;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Presents an operand pair, queues expectations, returns after the accepting edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] e0, input logic [2*W-1:0] e2, output int acc);
        int n;
        acc = -1;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready0) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", n);
            @(posedge clk);
            #1 in_valid = 1'b0;
            return;
        end
        q0.push_back(e0);
        q2.push_back(e2);
        @(posedge clk);
        #1;
        acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q2.size() != 0 || busy0 || busy2) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (q0.size() != 0 || q2.size() != 0 || busy0 || busy2) begin
            miscompares++;
            $display("FAIL drain_timeout: pending=%0d/%0d busy=%0b/%0b, required all idle",
                     q0.size(), q2.size(), busy0, busy2);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({out_valid0, out_valid2, busy0, busy2} !== 4'b0 || out_product0 !== '0 || out_product2 !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%0b/%0b busy=%0b/%0b product=%0d/%0d, required all 0",
                     out_valid0, out_valid2, busy0, busy2, out_product0, out_product2);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready0 !== 1'b1 || in_ready2 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %0b/%0b, required 1/1", in_ready0, in_ready2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        int acc, n;
        out_ready = 1'b1;
        do_op(6'd63, 6'd63, 12'd3969, ref_mul(6'd63, 6'd63, 2), acc);
        n = 0;
        while (!out_valid0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (n != W) begin
            miscompares++;
            $display("FAIL latency: out_valid after %0d cycles, required %0d", n, W);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int t0, t1, t2;
        out_ready = 1'b1;
        do_op(6'd0, 6'd45, 12'd0, 12'd0, t0);
        do_op(6'd45, 6'd1, 12'd45, 12'd0, t1);
        do_op(6'd1, 6'd63, 12'd63, 12'd60, t2);
        vectors++;
        if (t1 - t0 != W + 2 || t2 - t1 != W + 2) begin
            miscompares++;
            $display("FAIL back_to_back: spacing %0d,%0d cycles, required %0d", t1 - t0, t2 - t1, W + 2);
        end
        wait_drain();
    endtask

    task automatic test_out_stall();
        int acc, n;
        out_ready = 1'b0;
        do_op(6'd20, 6'd30, 12'd600, 12'd560, acc);
        n = 0;
        while (!out_valid0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        in_a = 6'd7;
        in_b = 6'd9;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid0 !== 1'b1 || out_product0 !== 12'd600 || out_product2 !== 12'd560 ||
                in_ready0 !== 1'b0 || in_ready2 !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold: valid=%0b product=%0d/%0d in_ready=%0b, required 1 600/560 0",
                         out_valid0, out_product0, out_product2, in_ready0);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        wait_drain();
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (busy0 !== 1'b0 || out_product0 !== 12'd600) begin
                miscompares++;
                $display("FAIL stall_no_capture: busy=%0b product=%0d, required 0 and 600", busy0, out_product0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        int acc;
        out_ready = 1'b1;
        do_op(6'd50, 6'd40, 12'd2000, ref_mul(6'd50, 6'd40, 2), acc);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid0, out_valid2, busy0, busy2} !== 4'b0 || out_product0 !== '0 || out_product2 !== '0) begin
            miscompares++;
            $display("FAIL mid_run_reset: valid=%0b busy=%0b product=%0d, required 0 0 0",
                     out_valid0, busy0, out_product0);
        end
        q0.delete();
        q2.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready0 !== 1'b1 || in_ready2 !== 1'b1 || out_valid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_ready: in_ready=%0b/%0b out_valid=%0b, required 1/1 0",
                     in_ready0, in_ready2, out_valid0);
        end
        @(posedge clk);
        #1;
        do_op(6'd12, 6'd11, 12'd132, 12'd96, acc);
        wait_drain();
    endtask

    task automatic test_approx();
        int acc;
        out_ready = 1'b1;
        do_op(6'd63, 6'd63, 12'd3969, 12'd3780, acc);
        do_op(6'd5, 6'd3, 12'd15, 12'd0, acc);
        wait_drain();
    endtask

    task automatic test_exhaustive();
        int acc;
        rand_ready = 1'b1;
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                do_op(W'(a), W'(b), ref_mul(W'(a), W'(b), 0), ref_mul(W'(a), W'(b), 2), acc);
            end
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_out_stall();
        test_reset_mid_run();
        test_approx();
        test_exhaustive();
        vectors++;
        if (q0.size() != 0 || q2.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: %0d/%0d products outstanding, required 0", q0.size(), q2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
